// File: rtl/direction_pkg.sv
// Shared constants, repeat FSM states and axis resolution for direction_conditioner.
// Build option: DIR_ACCEL_EN enables the repeat-rate acceleration.
package direction_pkg;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_MOVE_DIV        = 250000;
  localparam int DEF_ACCEL_MOVES     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_REPEAT
  } rpt_state_e;

  // Opposing directions on one axis cancel; the axes are independent.
  function automatic logic [3:0] resolve_dirs(input logic [3:0] s);
    logic [3:0] r;
    r = s;
    if (s[DIR_UP] && s[DIR_DOWN]) begin
      r[DIR_UP]   = 1'b0;
      r[DIR_DOWN] = 1'b0;
    end
    if (s[DIR_LEFT] && s[DIR_RIGHT]) begin
      r[DIR_LEFT]  = 1'b0;
      r[DIR_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a run-length debouncer for one button.
// The stable value flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_bit
  import direction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/direction_conditioner.sv
// Debounces four direction buttons, cancels opposing pairs and emits move pulses.
// Build option: DIR_ACCEL_EN halves the repeat interval after ACCEL_MOVES pulses.
module direction_conditioner
  import direction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MOVE_DIV        = DEF_MOVE_DIV,
  parameter int ACCEL_MOVES     = DEF_ACCEL_MOVES
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] Buttons,
  output logic [3:0] Direction,
  output logic [3:0] Held
);

  localparam int RW = $clog2(MOVE_DIV + 1);
  localparam logic [RW-1:0] MOVE_LAST = RW'(MOVE_DIV - 1);

  logic [3:0] stable;

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (Clock),
      .rst_n   (Reset_n),
      .btn_i   (Buttons[i]),
      .stable_o(stable[i])
    );
  end

  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [3:0]    dir_q, dir_d;
  logic [3:0]    held_q, held_d;
  logic [RW-1:0] last_cnt;

`ifdef DIR_ACCEL_EN
  localparam int HALF = (MOVE_DIV / 2 < 1) ? 1 : MOVE_DIV / 2;
  localparam logic [RW-1:0] HALF_LAST = RW'(HALF - 1);
  localparam int PW = $clog2(ACCEL_MOVES + 1);
  localparam logic [PW-1:0] PSAT = PW'(ACCEL_MOVES);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign last_cnt = (pcnt_q == PSAT) ? HALF_LAST : MOVE_LAST;

  always_comb begin
    pcnt_d = pcnt_q;
    if (held_q == 4'b0000) begin
      pcnt_d = '0;
    end else if (dir_d != 4'b0000 && pcnt_q != PSAT) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end
`else
  assign last_cnt = MOVE_LAST;
`endif

  always_comb begin
    held_d  = resolve_dirs(stable);
    state_d = state_q;
    rate_d  = rate_q;
    dir_d   = 4'b0000;
    if (held_q == 4'b0000) begin
      state_d = ST_IDLE;
      rate_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dir_d   = held_q;
          state_d = ST_FIRST;
          rate_d  = '0;
        end
        // The FIRST pulse cycle already counts toward the first repeat interval.
        ST_FIRST, ST_REPEAT: begin
          state_d = ST_REPEAT;
          if (rate_q >= last_cnt) begin
            dir_d  = held_q;
            rate_d = '0;
          end else begin
            rate_d = rate_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rate_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      rate_q  <= '0;
      dir_q   <= 4'b0000;
      held_q  <= 4'b0000;
`ifdef DIR_ACCEL_EN
      pcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      dir_q   <= dir_d;
      held_q  <= held_d;
`ifdef DIR_ACCEL_EN
      pcnt_q  <= pcnt_d;
`endif
    end
  end

  assign Direction = dir_q;
  assign Held      = held_q;

endmodule

// File: tb/tb_direction_conditioner.sv
// Bench for direction_conditioner: cycle-level behavioural model plus
// hand-computed checkpoints (DEBOUNCE_CYCLES=4, MOVE_DIV=8, ACCEL_MOVES=3).
module tb_direction_conditioner;

  localparam int D = 4;
  localparam int M = 8;
  localparam int A = 3;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [3:0] Buttons;
  logic [3:0] Direction;
  logic [3:0] Held;

  always #5 Clock = ~Clock;

  direction_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MOVE_DIV       (M),
    .ACCEL_MOVES    (A)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Buttons  (Buttons),
    .Direction(Direction),
    .Held     (Held)
  );

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    else
      n_pass++;
  endtask

  // Model: buttons seen two edges late; a bit flips once the last D
  // samples all disagree with it; Held lags by one edge; pulses are
  // timed from the last pulse.
  logic [3:0] hist [0:D];
  logic [3:0] m_stable, m_held, m_dir;
  bit         m_active;
  int         since, npulse;
  bit         m_valid = 1'b0;

  always @(posedge Clock) begin : model
    logic [3:0] ns, nh, nd;
    int iv;
    bit all;
    if (!Reset_n) begin
      for (int k = 0; k <= D; k++) hist[k] = 4'b0000;
      m_stable = 4'b0000;
      m_held   = 4'b0000;
      m_dir    = 4'b0000;
      m_active = 1'b0;
      since    = 0;
      npulse   = 0;
    end else begin
      ns = m_stable;
      for (int i = 0; i < 4; i++) begin
        all = 1'b1;
        for (int k = 1; k <= D; k++)
          if (hist[k][i] == m_stable[i]) all = 1'b0;
        if (all) ns[i] = ~m_stable[i];
      end
      nh = m_stable;
      if (nh[0] && nh[1]) nh[1:0] = 2'b00;
      if (nh[2] && nh[3]) nh[3:2] = 2'b00;
      nd = 4'b0000;
      if (m_held == 4'b0000) begin
        m_active = 1'b0;
        since    = 0;
        npulse   = 0;
      end else if (!m_active) begin
        nd       = m_held;
        m_active = 1'b1;
        since    = 0;
        npulse   = 1;
      end else begin
        since++;
        iv = M;
`ifdef DIR_ACCEL_EN
        if (npulse >= A) iv = (M / 2 < 1) ? 1 : M / 2;
`endif
        if (since >= iv) begin
          nd    = m_held;
          since = 0;
          if (npulse < A) npulse++;
        end
      end
      m_stable = ns;
      m_held   = nh;
      m_dir    = nd;
      for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = Buttons;
    end
    m_valid = 1'b1;
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      check("model_held", Held, m_held);
      check("model_dir", Direction, m_dir);
    end
  end

  // Lands on the falling edge after rising edge number t.
  task automatic at(input int t);
    while (cyc < t) @(negedge Clock);
  endtask

  int e, r, e2, g, h;

  initial begin
    Reset_n = 1'b0;
    Buttons = 4'b0000;
    repeat (3) @(negedge Clock);
    check("reset_held", Held, 4'b0000);
    check("reset_dir", Direction, 4'b0000);
    Reset_n = 1'b1;
    at(cyc + 3);

    // Up press, then Up+Right mid-interval.
    e = cyc;
    Buttons = 4'b0001;
    at(e + 6);  check("up_held_early", Held, 4'b0000);
    at(e + 7);  check("up_held_c7", Held, 4'b0001);
    at(e + 8);  check("up_pulse_c8", Direction, 4'b0001);
    at(e + 9);  check("up_gap_c9", Direction, 4'b0000);
    at(e + 16); check("up_pulse_c16", Direction, 4'b0001);
    Buttons = 4'b1001;
    at(e + 23); check("switch_held", Held, 4'b1001);
    check("switch_gap", Direction, 4'b0000);
    at(e + 24); check("switch_pulse", Direction, 4'b1001);

    // One-cycle reset while held in REPEAT.
    at(e + 26);
    Reset_n = 1'b0;
    at(e + 27);
    Reset_n = 1'b1;
    r = e + 27;
    check("rst_held", Held, 4'b0000);
    check("rst_dir", Direction, 4'b0000);
    at(r + 6);  check("rst_held_c6", Held, 4'b0000);
    at(r + 7);  check("rst_held_c7", Held, 4'b1001);
    at(r + 8);  check("rst_pulse_c8", Direction, 4'b1001);
    Buttons = 4'b0000;
    at(r + 20); check("release_held", Held, 4'b0000);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      Buttons[0] = ~Buttons[0];
      at(cyc + 3);
    end
    Buttons = 4'b0000;
    at(cyc + 8); check("bounce_held", Held, 4'b0000);

    // Axis conflicts.
    Buttons = 4'b0011;
    at(cyc + 10); check("ud_conflict", Held, 4'b0000);
    Buttons = 4'b0111;
    e2 = cyc;
    at(e2 + 7); check("ud_l_held", Held, 4'b0100);
    at(e2 + 8); check("ud_l_pulse", Direction, 4'b0100);
    Buttons = 4'b0000;
    at(cyc + 10);

    // Long hold, then release and re-press.
    g = cyc;
    Buttons = 4'b0001;
    at(g + 8);  check("hold_p8", Direction, 4'b0001);
    at(g + 16); check("hold_p16", Direction, 4'b0001);
    at(g + 24); check("hold_p24", Direction, 4'b0001);
`ifdef DIR_ACCEL_EN
    at(g + 27); check("accel_gap27", Direction, 4'b0000);
    at(g + 28); check("accel_p28", Direction, 4'b0001);
`else
    at(g + 28); check("flat_gap28", Direction, 4'b0000);
`endif
    at(g + 32); check("hold_p32", Direction, 4'b0001);
    Buttons = 4'b0000;
    at(cyc + 10);
    h = cyc;
    Buttons = 4'b0001;
    at(h + 8);  check("repress_p8", Direction, 4'b0001);
    at(h + 16); check("repress_p16", Direction, 4'b0001);
    at(h + 20); check("repress_gap20", Direction, 4'b0000);
    at(h + 24); check("repress_p24", Direction, 4'b0001);
    Buttons = 4'b0000;
    at(cyc + 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
